pfd_loop_ctrl: RTL and testbench

Digital loop controller that sits behind the phase-frequency detector and closes the loop: it samples the PFD `flagu`/`flagd` outputs, counts up/down events over fixed evaluation windows, and steps a DCO control word with a bang-bang rule. A four-state FSM moves from coarse acquisition to fine tracking and then to lock. It also holds the PFD in reset while the loop is disabled.

---
 rtl/pfd_loop_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pfd_loop_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pfd_loop_ctrl.sv
// pfd_loop_ctrl: bang-bang DCO loop controller behind a phase-frequency detector.
// Counts synchronized PFD up/down edges over fixed windows, steps the control word,
// and walks IDLE -> ACQUIRE (coarse) -> TRACK (fine) -> LOCKED.
module pfd_loop_ctrl #(
    parameter int unsigned CW        = 8,
    parameter int unsigned WIN       = 16,
    parameter int unsigned CNTW      = 6,
    parameter int unsigned INIT_CODE = 128,
    parameter int unsigned STEP_C    = 4,
    parameter int unsigned STEP_F    = 1,
    parameter int unsigned LOCK_N    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          flagu,
    input  logic          flagd,
    output logic          pfd_rst,
    output logic [CW-1:0] code,
    output logic          locked,
    output logic [1:0]    state,
    output logic          win_done
);
    localparam int unsigned WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned LW = $clog2(LOCK_N + 1);
    localparam logic [WW-1:0]   WinLast  = WW'(WIN - 1);
    localparam logic [CNTW-1:0] CntMax   = '1;
    localparam logic [CNTW:0]   DiffOne  = {{CNTW{1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CodeInit = CW'(INIT_CODE);
    localparam logic [CW-1:0]   StepC    = CW'(STEP_C);
    localparam logic [CW-1:0]   StepF    = CW'(STEP_F);
    localparam logic [LW-1:0]   LockN    = LW'(LOCK_N);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLocked  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      u_sync_q, d_sync_q;
    logic [WW-1:0]   win_q, win_d;
    logic [CNTW-1:0] up_q, up_d, dn_q, dn_d, up_tot, dn_tot;
    logic [LW-1:0]   lock_q, lock_d, lock_inc;
    logic            last_vld_q, last_vld_d, last_neg_q, last_neg_d;
    logic [CW-1:0]   code_q, code_d, step;
    logic [CW:0]     code_sum;
    logic            win_done_q, win_done_d;
    logic            up_edge, dn_edge, clr, eval;
    logic [CNTW:0]   diff;
    logic            diff_zero, diff_neg, diff_small, reversal;

    // Bits [1:0] synchronize the async flags; bit 2 is the previous value for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            u_sync_q <= '0;
            d_sync_q <= '0;
        end else begin
            u_sync_q <= {u_sync_q[1:0], flagu};
            d_sync_q <= {d_sync_q[1:0], flagd};
        end
    end

    // Window evaluation terms: counts include this cycle's edges, difference is CNTW+1 two's complement
    always_comb begin
        up_edge    = u_sync_q[1] & ~u_sync_q[2];
        dn_edge    = d_sync_q[1] & ~d_sync_q[2];
        up_tot     = (up_q == CntMax) ? up_q : up_q + {{(CNTW-1){1'b0}}, up_edge};
        dn_tot     = (dn_q == CntMax) ? dn_q : dn_q + {{(CNTW-1){1'b0}}, dn_edge};
        diff       = {1'b0, up_tot} - {1'b0, dn_tot};
        diff_zero  = (diff == '0);
        diff_neg   = diff[CNTW];
        diff_small = diff_zero || (diff == DiffOne) || (diff == '1);
        reversal   = last_vld_q && !diff_zero && (diff_neg != last_neg_q);
        clr        = (state_q == StIdle) || !enable;
        eval       = !clr && (win_q == WinLast);
        lock_inc   = lock_q + 1'b1;
        step       = (state_q == StAcquire) ? StepC : StepF;
        code_sum   = {1'b0, code_q} + {1'b0, step};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a dropped enable wins over any evaluation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StAcquire;
            StAcquire: if (eval && (diff_zero || reversal)) state_d = StTrack;
            StTrack:   if (eval && diff_small && (lock_inc == LockN)) state_d = StLocked;
            StLocked:  if (eval && !diff_small) state_d = StTrack;
        endcase
        if (!enable) state_d = StIdle;
    end

    // FSM-derived outputs
    always_comb begin
        pfd_rst  = (state_q == StIdle);
        locked   = (state_q == StLocked);
        state    = state_q;
        code     = code_q;
        win_done = win_done_q;
    end

    // Datapath next state: window/event counters, lock counter, last sign, control word
    always_comb begin
        win_d      = win_q + 1'b1;
        up_d       = up_tot;
        dn_d       = dn_tot;
        lock_d     = lock_q;
        last_vld_d = last_vld_q;
        last_neg_d = last_neg_q;
        code_d     = code_q;
        win_done_d = eval;
        if (clr) begin
            win_d      = '0;
            up_d       = '0;
            dn_d       = '0;
            lock_d     = '0;
            last_vld_d = 1'b0;
            last_neg_d = 1'b0;
        end else if (eval) begin
            win_d = '0;
            // Edges landing on the evaluation cycle also seed the next window
            up_d  = {{(CNTW-1){1'b0}}, up_edge};
            dn_d  = {{(CNTW-1){1'b0}}, dn_edge};
            if (!diff_zero && !diff_neg) begin
                code_d = code_sum[CW] ? '1 : code_sum[CW-1:0];
            end else if (diff_neg) begin
                code_d = (code_q < step) ? '0 : code_q - step;
            end
            if (state_q == StAcquire) begin
                lock_d = '0;
                if (!diff_zero) begin
                    last_vld_d = 1'b1;
                    last_neg_d = diff_neg;
                end
            end else begin
                last_vld_d = 1'b0;
                last_neg_d = 1'b0;
                if (!diff_small) begin
                    lock_d = '0;
                end else if (state_q == StTrack) begin
                    lock_d = lock_inc;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q      <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            lock_q     <= '0;
            last_vld_q <= 1'b0;
            last_neg_q <= 1'b0;
            code_q     <= CodeInit;
            win_done_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            lock_q     <= lock_d;
            last_vld_q <= last_vld_d;
            last_neg_q <= last_neg_d;
            code_q     <= code_d;
            win_done_q <= win_done_d;
        end
    end

endmodule

// File: tb/tb_pfd_loop_ctrl.sv
// Scoreboard bench for pfd_loop_ctrl: stimulus pushes expected window results,
// a negedge monitor pops one entry per win_done pulse on each instance.
module tb_pfd_loop_ctrl;
    typedef struct packed {
        logic [7:0] code;
        logic [1:0] st;
        logic       lk;
    } exp_t;

    logic       clk, reset;
    logic       m_en, m_u, m_d, m_pr, m_lk, m_wd;
    logic [7:0] m_code;
    logic [1:0] m_state;
    logic       a_en, tog;
    logic       h_pr, h_lk, h_wd, l_pr, l_lk, l_wd;
    logic [7:0] h_code, l_code;
    logic [1:0] h_state, l_state;
    logic       c_en, c_u, c_d, c_pr, c_lk, c_wd;
    logic [7:0] c_code;
    logic [1:0] c_state;

    exp_t q_m[$], q_h[$], q_l[$], q_c[$];
    int   checks = 0;
    int   errors = 0;

    pfd_loop_ctrl dut (
        .clk(clk), .reset(reset), .enable(m_en), .flagu(m_u), .flagd(m_d),
        .pfd_rst(m_pr), .code(m_code), .locked(m_lk), .state(m_state), .win_done(m_wd)
    );
    pfd_loop_ctrl #(.INIT_CODE(254)) dut_h (
        .clk(clk), .reset(reset), .enable(a_en), .flagu(tog), .flagd(1'b0),
        .pfd_rst(h_pr), .code(h_code), .locked(h_lk), .state(h_state), .win_done(h_wd)
    );
    pfd_loop_ctrl #(.INIT_CODE(2)) dut_l (
        .clk(clk), .reset(reset), .enable(a_en), .flagu(1'b0), .flagd(tog),
        .pfd_rst(l_pr), .code(l_code), .locked(l_lk), .state(l_state), .win_done(l_wd)
    );
    pfd_loop_ctrl #(.WIN(160)) dut_c (
        .clk(clk), .reset(reset), .enable(c_en), .flagu(c_u), .flagd(c_d),
        .pfd_rst(c_pr), .code(c_code), .locked(c_lk), .state(c_state), .win_done(c_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input int s, input int l);
        exp_t e;
        e.code = 8'(c);
        e.st   = 2'(s);
        e.lk   = 1'(l);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [7:0] c, input logic [1:0] s,
                       input logic l);
        chk({nm, "_code"}, int'(c), int'(e.code));
        chk({nm, "_state"}, int'(s), int'(e.st));
        chk({nm, "_locked"}, int'(l), int'(e.lk));
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s_win_done: got pulse expected none", nm);
    endtask

    // Monitor: every win_done pulse consumes exactly one expected entry
    always @(negedge clk) begin
        if (m_wd) begin
            if (q_m.size() == 0) unexpected("m");
            else cmp("m", q_m.pop_front(), m_code, m_state, m_lk);
        end
        if (h_wd) begin
            if (q_h.size() == 0) unexpected("h");
            else cmp("h", q_h.pop_front(), h_code, h_state, h_lk);
        end
        if (l_wd) begin
            if (q_l.size() == 0) unexpected("l");
            else cmp("l", q_l.pop_front(), l_code, l_state, l_lk);
        end
        if (c_wd) begin
            if (q_c.size() == 0) unexpected("c");
            else cmp("c", q_c.pop_front(), c_code, c_state, c_lk);
        end
    end

    // Starts at the negedge of window index 0; issues two-cycle pulses, then waits for win_done
    task automatic run_window(input bit sel_c, input int nu, input int nd, input exp_t e,
                              input int win);
        int n;
        n = 0;
        if (sel_c) q_c.push_back(e);
        else q_m.push_back(e);
        for (int k = 0; k < ((nu > nd) ? nu : nd); k++) begin
            if (sel_c) begin
                c_u = (k < nu);
                c_d = (k < nd);
            end else begin
                m_u = (k < nu);
                m_d = (k < nd);
            end
            @(negedge clk); n++;
            c_u = 1'b0; c_d = 1'b0; m_u = 1'b0; m_d = 1'b0;
            @(negedge clk); n++;
        end
        while (!(sel_c ? c_wd : m_wd) && n < win + 8) begin
            @(negedge clk); n++;
        end
        chk(sel_c ? "c_win_len" : "m_win_len", n, win);
    endtask

    initial begin
        reset = 1'b1;
        m_en = 1'b1; m_u = 1'b0; m_d = 1'b0;
        a_en = 1'b0; tog = 1'b0;
        c_en = 1'b0; c_u = 1'b0; c_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", int'(m_code), 128);
        chk("rst_state", int'(m_state), 0);
        chk("rst_pfd_rst", int'(m_pr), 1);
        chk("rst_locked", int'(m_lk), 0);
        chk("rst_win_done", int'(m_wd), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("start_state", int'(m_state), 1);
        chk("start_pfd_rst", int'(m_pr), 0);

        // Coarse acquisition upward
        run_window(1'b0, 5, 0, mk(132, 1, 0), 16);
        run_window(1'b0, 5, 0, mk(136, 1, 0), 16);
        run_window(1'b0, 5, 0, mk(140, 1, 0), 16);

        // Enable drop mid-window: partial counts must be discarded
        run_window_partial();
        m_en = 1'b0;
        @(negedge clk);
        chk("drop_state", int'(m_state), 0);
        chk("drop_pfd_rst", int'(m_pr), 1);
        chk("drop_code", int'(m_code), 140);
        chk("drop_locked", int'(m_lk), 0);
        repeat (20) @(negedge clk);
        m_en = 1'b1;
        @(negedge clk);
        chk("reen_state", int'(m_state), 1);
        chk("reen_pfd_rst", int'(m_pr), 0);

        // Clean window with last sign cleared: no reversal yet
        run_window(1'b0, 0, 5, mk(136, 1, 0), 16);
        // Reversal moves to TRACK, coarse step still applied
        run_window(1'b0, 5, 0, mk(140, 2, 0), 16);
        // Balanced windows build lock
        for (int i = 0; i < 4; i++) begin
            run_window(1'b0, 3, 3, mk(140, (i == 3) ? 3 : 2, (i == 3) ? 1 : 0), 16);
        end
        // Large imbalance drops back to TRACK with a fine step
        run_window(1'b0, 4, 0, mk(141, 2, 0), 16);
        m_en = 1'b0;

        // Control word saturation at both ends
        q_h.push_back(mk(255, 1, 0));
        q_h.push_back(mk(255, 1, 0));
        q_l.push_back(mk(0, 1, 0));
        q_l.push_back(mk(0, 1, 0));
        a_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 34; i++) begin
            tog = ~tog;
            @(negedge clk);
        end
        a_en = 1'b0;
        tog  = 1'b0;

        // Event counter saturation: 70 ups clip to 63
        c_en = 1'b1;
        @(negedge clk);
        run_window(1'b1, 70, 0, mk(132, 1, 0), 160);
        // 70 ups against 10 downs: clipped count keeps the difference positive
        run_window(1'b1, 70, 10, mk(136, 1, 0), 160);
        c_en = 1'b0;

        repeat (5) @(negedge clk);
        chk("q_m_empty", q_m.size(), 0);
        chk("q_h_empty", q_h.size(), 0);
        chk("q_l_empty", q_l.size(), 0);
        chk("q_c_empty", q_c.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Five up pulses into the current window, leaving it unevaluated
    task automatic run_window_partial();
        for (int k = 0; k < 5; k++) begin
            m_u = 1'b1;
            @(negedge clk);
            m_u = 1'b0;
            @(negedge clk);
        end
    endtask

endmodule
